// File: rtl/led_pattern_seq.sv
// led_pattern_seq: N-LED chase / fill / bounce sequencer with step prescaler.
// Define LED_PATTERN_SEQ_HOLD_EN to add a 'hold' input that freezes the run.
module led_pattern_seq #(
   parameter int N   = 8,
   parameter int DIV = 1,
   parameter int PW  = $clog2(N),
   parameter int CW  = $clog2(DIV + 1)
) (
   input  logic          ck,
   input  logic          rs,
   input  logic          en,
   input  logic [1:0]    mode,
   input  logic          dir,
`ifdef LED_PATTERN_SEQ_HOLD_EN
   input  logic          hold,
`endif
   output logic [N-1:0]  y,
   output logic [PW-1:0] pos,
   output logic          busy,
   output logic          done
);

   typedef enum logic { OFF, RUN } state_t;
   typedef enum logic { UP, DOWN } phase_t;

   localparam logic [PW-1:0] LAST  = PW'(N - 1);
   localparam logic [PW-1:0] LAST1 = PW'(N - 2);
   localparam logic [CW-1:0] CMAX  = CW'(DIV - 1);
   localparam logic [N-1:0]  ONES  = '1;
   localparam logic [N-1:0]  ONE   = N'(1);
   localparam logic [1:0]    M_FIL = 2'b01;
   localparam logic [1:0]    M_BNC = 2'b10;
   localparam logic [1:0]    M_OFF = 2'b11;

   state_t        state, state_d;
   phase_t        phase, phase_d;
   logic [PW-1:0] pos_d;
   logic [CW-1:0] cnt, cnt_d;
   logic [1:0]    m_q, m_d;
   logic          d_q, d_d;
   logic          done_d;
   logic          tick;
   logic          frz;
   logic [PW-1:0] k;

`ifdef LED_PATTERN_SEQ_HOLD_EN
   assign frz = hold;
`else
   assign frz = 1'b0;
`endif

   // Step strobe: last count of the prescaler, suppressed while frozen.
   always_comb begin
      tick = !frz && (cnt == CMAX);
   end

   // Next-state logic: prescaler, run/off control and position stepping.
   always_comb begin
      state_d = state;
      phase_d = phase;
      pos_d   = pos;
      m_d     = m_q;
      d_d     = d_q;
      done_d  = 1'b0;
      cnt_d   = cnt;
      if (!frz) begin
         cnt_d = tick ? '0 : cnt + 1'b1;
      end
      if (tick) begin
         unique case (state)
            OFF: begin
               if (en && mode != M_OFF) begin
                  state_d = RUN;
                  pos_d   = '0;
                  phase_d = UP;
                  m_d     = mode;
                  d_d     = dir;
                  cnt_d   = '0;
               end
            end
            RUN: begin
               if (!en || mode != m_q) begin
                  state_d = OFF;
                  pos_d   = '0;
                  phase_d = UP;
               end else if (m_q == M_BNC && phase == DOWN) begin
                  if (pos != '0) begin
                     pos_d = pos - 1'b1;
                  end else begin
                     state_d = OFF;
                     phase_d = UP;
                     done_d  = 1'b1;
                  end
               end else if (pos != LAST) begin
                  pos_d = pos + 1'b1;
               end else if (m_q == M_BNC) begin
                  phase_d = DOWN;
                  pos_d   = LAST1;
               end else begin
                  state_d = OFF;
                  pos_d   = '0;
                  done_d  = 1'b1;
               end
            end
         endcase
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge ck) begin
      if (!rs) begin
         state <= OFF;
         phase <= UP;
         pos   <= '0;
         cnt   <= '0;
         m_q   <= '0;
         d_q   <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_d;
         phase <= phase_d;
         pos   <= pos_d;
         cnt   <= cnt_d;
         m_q   <= m_d;
         d_q   <= d_d;
         done  <= done_d;
      end
   end

   // LED decode from registered state only; k counts from the start end.
   always_comb begin
      k = d_q ? pos : LAST - pos;
      y = '0;
      if (state == RUN) begin
         if (m_q == M_FIL) begin
            y = d_q ? (ONES >> (LAST - k)) : (ONES << k);
         end else begin
            y = ONE << k;
         end
      end
   end

   assign busy = (state == RUN);

endmodule

// File: tb/tb_led_pattern_seq.sv
// tb_led_pattern_seq: scoreboard bench for led_pattern_seq (N=8).
// One instance runs DIV=1, another DIV=4; expectations are tagged per cycle.
module tb_led_pattern_seq;

   logic       ck = 1'b0;
   logic       rs = 1'b0;
   logic       en = 1'b0;
   logic       dir = 1'b0;
   logic [1:0] mode = 2'd0;
`ifdef LED_PATTERN_SEQ_HOLD_EN
   logic       hold = 1'b0;
`endif

   logic [7:0] y1, y4;
   logic [2:0] p1, p4;
   logic       b1, b4, d1, d4;

   typedef struct {
      int         cyc;
      bit         sel;
      logic [7:0] y;
      logic       b;
      logic       d;
      logic [2:0] p;
      bit         pc;
   } exp_t;

   exp_t sb[$];
   exp_t em;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 ck = ~ck;

   led_pattern_seq #(.N(8), .DIV(1)) u1 (
      .ck(ck), .rs(rs), .en(en), .mode(mode), .dir(dir),
`ifdef LED_PATTERN_SEQ_HOLD_EN
      .hold(hold),
`endif
      .y(y1), .pos(p1), .busy(b1), .done(d1)
   );

   led_pattern_seq #(.N(8), .DIV(4)) u4 (
      .ck(ck), .rs(rs), .en(en), .mode(mode), .dir(dir),
`ifdef LED_PATTERN_SEQ_HOLD_EN
      .hold(hold),
`endif
      .y(y4), .pos(p4), .busy(b4), .done(d4)
   );

   always @(posedge ck) cyc <= cyc + 1;

   task automatic chk(input string nm, input int c,
                      input logic [7:0] act, input logic [7:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, c, act, req);
      end
   endtask

   // Monitor: pop every expectation due this cycle and compare.
   always @(negedge ck) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         em = sb.pop_front();
         if (em.cyc < cyc) begin
            n_chk++;
            n_err++;
            $display("FAIL missed cyc=%0d got=stale want=%0d", em.cyc, cyc);
         end else if (em.sel) begin
            chk("y4", cyc, y4, em.y);
            chk("busy4", cyc, {7'd0, b4}, {7'd0, em.b});
            chk("done4", cyc, {7'd0, d4}, {7'd0, em.d});
            if (em.pc) chk("pos4", cyc, {5'd0, p4}, {5'd0, em.p});
         end else begin
            chk("y1", cyc, y1, em.y);
            chk("busy1", cyc, {7'd0, b1}, {7'd0, em.b});
            chk("done1", cyc, {7'd0, d1}, {7'd0, em.d});
            if (em.pc) chk("pos1", cyc, {5'd0, p1}, {5'd0, em.p});
         end
      end
   end

   // Drive inputs for the next edge and queue the outputs expected after it.
   task automatic st(input logic r, input logic e, input logic [1:0] m,
                     input logic d, input bit s, input logic [7:0] ey,
                     input logic eb, input logic ed,
                     input logic [2:0] ep = 3'd0, input bit pc = 1'b0);
      exp_t x;
      rs   = r;
      en   = e;
      mode = m;
      dir  = d;
      x.cyc = cyc + 1;
      x.sel = s;
      x.y   = ey;
      x.b   = eb;
      x.d   = ed;
      x.p   = ep;
      x.pc  = pc;
      sb.push_back(x);
      @(posedge ck);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge ck);
      #1;
      // reset held with en=1, chase selected
      for (int i = 0; i < 3; i++) st(0, 1, 2'd0, 0, 0, 8'h00, 0, 0, 3'd0, 1);
      // chase, dir=0, then restart after one blank cycle
      for (int i = 0; i < 8; i++) st(1, 1, 2'd0, 0, 0, 8'h80 >> i, 1, 0);
      st(1, 1, 2'd0, 0, 0, 8'h00, 0, 1);
      st(1, 1, 2'd0, 0, 0, 8'h80, 1, 0);
      // dir flipped mid-run is ignored until the next start
      for (int i = 1; i < 8; i++) st(1, 1, 2'd0, 1, 0, 8'h80 >> i, 1, 0);
      st(1, 1, 2'd0, 1, 0, 8'h00, 0, 1);
      for (int i = 0; i < 8; i++) st(1, 1, 2'd0, 1, 0, 8'h01 << i, 1, 0);
      st(1, 1, 2'd0, 1, 0, 8'h00, 0, 1);
      // fill, dir=0, with position
      for (int i = 0; i < 8; i++)
         st(1, 1, 2'd1, 0, 0, 8'hFF << (7 - i), 1, 0, 3'(i), 1);
      st(1, 1, 2'd1, 0, 0, 8'h00, 0, 1);
      // bounce, dir=1: 15 lit steps
      for (int i = 0; i < 8; i++) st(1, 1, 2'd2, 1, 0, 8'h01 << i, 1, 0);
      for (int i = 6; i >= 0; i--) st(1, 1, 2'd2, 1, 0, 8'h01 << i, 1, 0);
      st(1, 1, 2'd2, 1, 0, 8'h00, 0, 1);
      st(1, 0, 2'd2, 1, 0, 8'h00, 0, 0);
      // reserved mode never starts
      st(1, 1, 2'd3, 0, 0, 8'h00, 0, 0);
      st(1, 1, 2'd3, 0, 0, 8'h00, 0, 0);
      // abort by mode change, then fill starts
      for (int i = 0; i < 4; i++) st(1, 1, 2'd0, 0, 0, 8'h80 >> i, 1, 0);
      st(1, 1, 2'd1, 0, 0, 8'h00, 0, 0);
      st(1, 1, 2'd1, 0, 0, 8'h80, 1, 0);
      st(1, 1, 2'd1, 0, 0, 8'hC0, 1, 0);
      // abort by en low, stays off
      for (int i = 0; i < 3; i++) st(1, 0, 2'd1, 0, 0, 8'h00, 0, 0);

      // DIV=4: each step held four cycles, reset mid-run restarts cleanly
      st(0, 1, 2'd0, 0, 1, 8'h00, 0, 0);
      for (int i = 0; i < 3; i++) st(1, 1, 2'd0, 0, 1, 8'h00, 0, 0);
      for (int i = 0; i < 4; i++) st(1, 1, 2'd0, 0, 1, 8'h80, 1, 0, 3'd0, 1);
      for (int i = 0; i < 4; i++) st(1, 1, 2'd0, 0, 1, 8'h40, 1, 0, 3'd1, 1);
      for (int i = 0; i < 2; i++) st(1, 1, 2'd0, 0, 1, 8'h20, 1, 0);
      st(0, 1, 2'd0, 0, 1, 8'h00, 0, 0, 3'd0, 1);
      for (int i = 0; i < 3; i++) st(1, 1, 2'd0, 0, 1, 8'h00, 0, 0);
      for (int i = 0; i < 4; i++) st(1, 1, 2'd0, 0, 1, 8'h80, 1, 0);
      st(1, 1, 2'd0, 0, 1, 8'h40, 1, 0);

`ifdef LED_PATTERN_SEQ_HOLD_EN
      // hold freezes fill at C0 mid-count, then the count resumes
      st(0, 1, 2'd1, 0, 1, 8'h00, 0, 0);
      for (int i = 0; i < 3; i++) st(1, 1, 2'd1, 0, 1, 8'h00, 0, 0);
      for (int i = 0; i < 4; i++) st(1, 1, 2'd1, 0, 1, 8'h80, 1, 0);
      for (int i = 0; i < 2; i++) st(1, 1, 2'd1, 0, 1, 8'hC0, 1, 0);
      hold = 1'b1;
      for (int i = 0; i < 10; i++) st(1, 1, 2'd1, 0, 1, 8'hC0, 1, 0, 3'd1, 1);
      hold = 1'b0;
      for (int i = 0; i < 2; i++) st(1, 1, 2'd1, 0, 1, 8'hC0, 1, 0);
      st(1, 1, 2'd1, 0, 1, 8'hE0, 1, 0, 3'd2, 1);
`endif

      repeat (2) @(negedge ck);
      n_chk++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain got=%0d want=0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule
